dmem_arbiter: RTL and testbench

Two-port arbiter and sequencer in front of the single-port 32-word data memory (combinational read, write on posedge Clock when ReadWrite=1). Port 0 is the CPU load/store path; port 1 is the debug/loader path. Requests are serialised through a 3-state FSM with round-robin tie-break. Each request gets a one-cycle ack pulse with registered read data, plus an error flag for misaligned or out-of-range addresses.

---
 rtl/dmem_arbiter_if.sv | 53 +++++
 rtl/dmem_arbiter.sv | 118 +++++++++++
 tb/tb_dmem_arbiter.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesters, the dmem_arbiter and the data memory.
//   p0_*/p1_* : req/we/addr/wdata toward the arbiter, ack/err/rdata back to each requester
//   mem_*     : address, write data, ReadWrite strobe and combinational read data of the memory
//   busy      : arbiter is not idle
//   grant_id  : port owning the current or last transaction
// Modport slave is the arbiter side; modport master is the requester/memory side.
interface dmem_arbiter_if #(
  parameter int unsigned DATA_W = 32
);
  logic              p0_req;
  logic              p0_we;
  logic [31:0]       p0_addr;
  logic [DATA_W-1:0] p0_wdata;
  logic              p0_ack;
  logic              p0_err;
  logic [DATA_W-1:0] p0_rdata;

  logic              p1_req;
  logic              p1_we;
  logic [31:0]       p1_addr;
  logic [DATA_W-1:0] p1_wdata;
  logic              p1_ack;
  logic              p1_err;
  logic [DATA_W-1:0] p1_rdata;

  logic [31:0]       mem_addr;
  logic [DATA_W-1:0] mem_datain;
  logic              mem_rw;
  logic [DATA_W-1:0] mem_dataout;

  logic              busy;
  logic              grant_id;

  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata,
    input  p1_req, p1_we, p1_addr, p1_wdata,
    input  mem_dataout,
    output p0_ack, p0_err, p0_rdata,
    output p1_ack, p1_err, p1_rdata,
    output mem_addr, mem_datain, mem_rw,
    output busy, grant_id
  );

  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata,
    output p1_req, p1_we, p1_addr, p1_wdata,
    output mem_dataout,
    input  p0_ack, p0_err, p0_rdata,
    input  p1_ack, p1_err, p1_rdata,
    input  mem_addr, mem_datain, mem_rw,
    input  busy, grant_id
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer in front of a single-port data memory.
// Requests are sampled only in idle, serialised as Idle -> Access -> Done, with round-robin
// tie-break when both ports request. Each transaction ends in a one-cycle ack to the winner,
// with err flagging misaligned or out-of-range addresses (such writes never reach memory).
// Ports:
//   Clock : system clock, all state on posedge
//   Reset : synchronous, active-high
//   bus   : dmem_arbiter_if slave modport (both request ports, memory port, busy, grant_id)
module dmem_arbiter #(
  parameter int unsigned DEPTH_BITS = 5,
  parameter int unsigned DATA_W     = 32
) (
  input logic           Clock,
  input logic           Reset,
  dmem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  state_e            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              grant_q, grant_d;
  logic              we_q, we_d;
  logic [31:0]       addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;

  logic              win;
  logic              err0, err1;

  // Misaligned, or any bit above the word index set.
  function automatic logic addr_err(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a[31:DEPTH_BITS+2] != '0);
  endfunction

  assign err0 = addr_err(bus.p0_addr);
  assign err1 = addr_err(bus.p1_addr);

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    err_d        = err_q;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    win          = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.p0_req || bus.p1_req) begin
          // Contention goes to the port that did not win last time.
          if (bus.p0_req && bus.p1_req) win = ~last_grant_q;
          else                          win = bus.p1_req;
          grant_d      = win;
          last_grant_d = win;
          we_d         = win ? bus.p1_we    : bus.p0_we;
          addr_d       = win ? bus.p1_addr  : bus.p0_addr;
          wdata_d      = win ? bus.p1_wdata : bus.p0_wdata;
          err_d        = win ? err1         : err0;
          state_d      = StAccess;
        end
      end
      StAccess: begin
        if (!we_q) begin
          if (grant_q) rdata1_d = err_q ? '0 : bus.mem_dataout;
          else         rdata0_d = err_q ? '0 : bus.mem_dataout;
        end
        state_d = StDone;
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      err_q        <= 1'b0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      err_q        <= err_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
    end
  end

  // Reset gates the strobe combinationally so a write caught mid-access never commits.
  assign bus.mem_rw     = (state_q == StAccess) && we_q && !err_q && !Reset;
  assign bus.mem_addr   = addr_q;
  assign bus.mem_datain = wdata_q;

  assign bus.p0_ack   = (state_q == StDone) && !grant_q;
  assign bus.p1_ack   = (state_q == StDone) &&  grant_q;
  assign bus.p0_err   = (state_q == StDone) && !grant_q && err_q;
  assign bus.p1_err   = (state_q == StDone) &&  grant_q && err_q;
  assign bus.p0_rdata = rdata0_q;
  assign bus.p1_rdata = rdata1_q;
  assign bus.busy     = (state_q != StIdle);
  assign bus.grant_id = grant_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Table-driven bench for dmem_arbiter: one table row per clock cycle (inputs held for the
// cycle, outputs compared mid-cycle), followed by hand-written memory and latency checks.
module tb_dmem_arbiter;

  localparam logic [31:0] DB = 32'hDEADBEEF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic load = 1'b1;
  logic [31:0] ram [32];

  int n_vec = 0;
  int n_bad = 0;

  dmem_arbiter_if #(.DATA_W(32)) bus ();

  dmem_arbiter #(.DEPTH_BITS(5), .DATA_W(32)) u_dut (
    .Clock (clk),
    .Reset (rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Memory model: combinational read, write on posedge when ReadWrite=1, preload ram[i]=i*i.
  assign bus.mem_dataout = ram[bus.mem_addr[6:2]];
  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 32; i++) ram[i] <= i * i;
    end else if (bus.mem_rw) begin
      ram[bus.mem_addr[6:2]] <= bus.mem_datain;
    end
  end

  typedef struct {
    logic        rst;
    logic        r0, w0;
    logic [31:0] a0, d0;
    logic        r1, w1;
    logic [31:0] a1, d1;
    logic [3:0]  ae;   // {p0_ack, p0_err, p1_ack, p1_err}
    logic [31:0] rd0, rd1;
    logic        busy, gid, rw;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(input logic rs,
                             input logic r0, input logic w0, input logic [31:0] a0,
                             input logic [31:0] d0,
                             input logic r1, input logic w1, input logic [31:0] a1,
                             input logic [31:0] d1,
                             input logic [3:0] ae, input logic [31:0] rd0,
                             input logic [31:0] rd1,
                             input logic bz, input logic gid, input logic rw);
    vec_t t;
    t.rst = rs; t.r0 = r0; t.w0 = w0; t.a0 = a0; t.d0 = d0;
    t.r1 = r1; t.w1 = w1; t.a1 = a1; t.d1 = d1;
    t.ae = ae; t.rd0 = rd0; t.rd1 = rd1; t.busy = bz; t.gid = gid; t.rw = rw;
    return t;
  endfunction

  task automatic chk(input string name, input int row, input logic [31:0] act,
                     input logic [31:0] exp);
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int lat;

    // Scenario: p0 read 0x0C (addr changed during ACCESS must be ignored)
    vecs.push_back(v(0, 0,0,0,0,        0,0,0,0,      4'b0000, 0,0, 0,0,0));
    vecs.push_back(v(0, 1,0,'h0C,0,     0,0,0,0,      4'b0000, 0,0, 0,0,0));
    vecs.push_back(v(0, 1,0,'h10,0,     0,0,0,0,      4'b0000, 0,0, 1,0,0));
    vecs.push_back(v(0, 1,0,'h10,0,     0,0,0,0,      4'b1000, 9,0, 1,0,0));
    vecs.push_back(v(0, 0,0,0,0,        0,0,0,0,      4'b0000, 9,0, 0,0,0));
    // p1 write then read of 0x10
    vecs.push_back(v(0, 0,0,0,0,        1,1,'h10,DB,  4'b0000, 9,0, 0,0,0));
    vecs.push_back(v(0, 0,0,0,0,        1,1,'h10,DB,  4'b0000, 9,0, 1,1,1));
    vecs.push_back(v(0, 0,0,0,0,        1,1,'h10,DB,  4'b0010, 9,0, 1,1,0));
    vecs.push_back(v(0, 0,0,0,0,        0,0,0,0,      4'b0000, 9,0, 0,1,0));
    vecs.push_back(v(0, 0,0,0,0,        1,0,'h10,0,   4'b0000, 9,0, 0,1,0));
    vecs.push_back(v(0, 0,0,0,0,        1,0,'h10,0,   4'b0000, 9,0, 1,1,0));
    vecs.push_back(v(0, 0,0,0,0,        1,0,'h10,0,   4'b0010, 9,DB, 1,1,0));
    vecs.push_back(v(0, 0,0,0,0,        0,0,0,0,      4'b0000, 9,DB, 0,1,0));
    // Reset, then both ports request continuously: grants 0,1,0
    vecs.push_back(v(1, 0,0,0,0,        0,0,0,0,      4'b0000, 9,DB, 0,1,0));
    vecs.push_back(v(0, 1,0,'h04,0,     1,0,'h08,0,   4'b0000, 0,0, 0,0,0));
    vecs.push_back(v(0, 1,0,'h04,0,     1,0,'h08,0,   4'b0000, 0,0, 1,0,0));
    vecs.push_back(v(0, 1,0,'h04,0,     1,0,'h08,0,   4'b1000, 1,0, 1,0,0));
    vecs.push_back(v(0, 1,0,'h04,0,     1,0,'h08,0,   4'b0000, 1,0, 0,0,0));
    vecs.push_back(v(0, 1,0,'h04,0,     1,0,'h08,0,   4'b0000, 1,0, 1,1,0));
    vecs.push_back(v(0, 1,0,'h04,0,     1,0,'h08,0,   4'b0010, 1,4, 1,1,0));
    vecs.push_back(v(0, 1,0,'h04,0,     1,0,'h08,0,   4'b0000, 1,4, 0,1,0));
    vecs.push_back(v(0, 1,0,'h04,0,     1,0,'h08,0,   4'b0000, 1,4, 1,0,0));
    vecs.push_back(v(0, 1,0,'h04,0,     1,0,'h08,0,   4'b1000, 1,4, 1,0,0));
    vecs.push_back(v(0, 0,0,0,0,        0,0,0,0,      4'b0000, 1,4, 0,0,0));
    // p0 write misaligned 0x06, then out-of-range 0x80: err, no mem_rw
    vecs.push_back(v(0, 1,1,'h06,'h1234, 0,0,0,0,     4'b0000, 1,4, 0,0,0));
    vecs.push_back(v(0, 1,1,'h06,'h1234, 0,0,0,0,     4'b0000, 1,4, 1,0,0));
    vecs.push_back(v(0, 1,1,'h06,'h1234, 0,0,0,0,     4'b1100, 1,4, 1,0,0));
    vecs.push_back(v(0, 0,0,0,0,        0,0,0,0,      4'b0000, 1,4, 0,0,0));
    vecs.push_back(v(0, 1,1,'h80,'h1234, 0,0,0,0,     4'b0000, 1,4, 0,0,0));
    vecs.push_back(v(0, 1,1,'h80,'h1234, 0,0,0,0,     4'b0000, 1,4, 1,0,0));
    vecs.push_back(v(0, 1,1,'h80,'h1234, 0,0,0,0,     4'b1100, 1,4, 1,0,0));
    vecs.push_back(v(0, 0,0,0,0,        0,0,0,0,      4'b0000, 1,4, 0,0,0));
    // p1 read of a bad address returns 0
    vecs.push_back(v(0, 0,0,0,0,        1,0,'h83,0,   4'b0000, 1,4, 0,0,0));
    vecs.push_back(v(0, 0,0,0,0,        1,0,'h83,0,   4'b0000, 1,4, 1,1,0));
    vecs.push_back(v(0, 0,0,0,0,        1,0,'h83,0,   4'b0011, 1,0, 1,1,0));
    vecs.push_back(v(0, 0,0,0,0,        0,0,0,0,      4'b0000, 1,0, 0,1,0));
    // p0 write 0x55 to 0x14 with Reset in ACCESS
    vecs.push_back(v(0, 1,1,'h14,'h55,  0,0,0,0,      4'b0000, 1,0, 0,1,0));
    vecs.push_back(v(1, 1,1,'h14,'h55,  0,0,0,0,      4'b0000, 1,0, 1,0,0));
    vecs.push_back(v(0, 0,0,0,0,        0,0,0,0,      4'b0000, 0,0, 0,0,0));
    // p1 read 0x08 with Reset in DONE: ack still visible
    vecs.push_back(v(0, 0,0,0,0,        1,0,'h08,0,   4'b0000, 0,0, 0,0,0));
    vecs.push_back(v(0, 0,0,0,0,        1,0,'h08,0,   4'b0000, 0,0, 1,1,0));
    vecs.push_back(v(1, 0,0,0,0,        1,0,'h08,0,   4'b0010, 0,4, 1,1,0));
    vecs.push_back(v(0, 0,0,0,0,        0,0,0,0,      4'b0000, 0,0, 0,0,0));
    // p0 read 0x00 with req held across ack: back-to-back transactions
    vecs.push_back(v(0, 1,0,'h00,0,     0,0,0,0,      4'b0000, 0,0, 0,0,0));
    vecs.push_back(v(0, 1,0,'h00,0,     0,0,0,0,      4'b0000, 0,0, 1,0,0));
    vecs.push_back(v(0, 1,0,'h00,0,     0,0,0,0,      4'b1000, 0,0, 1,0,0));
    vecs.push_back(v(0, 1,0,'h00,0,     0,0,0,0,      4'b0000, 0,0, 0,0,0));
    vecs.push_back(v(0, 1,0,'h00,0,     0,0,0,0,      4'b0000, 0,0, 1,0,0));
    vecs.push_back(v(0, 1,0,'h00,0,     0,0,0,0,      4'b1000, 0,0, 1,0,0));
    vecs.push_back(v(0, 0,0,0,0,        0,0,0,0,      4'b0000, 0,0, 0,0,0));

    bus.p0_req = 0; bus.p0_we = 0; bus.p0_addr = 0; bus.p0_wdata = 0;
    bus.p1_req = 0; bus.p1_we = 0; bus.p1_addr = 0; bus.p1_wdata = 0;
    rst = 1'b1;
    load = 1'b1;
    step();
    step();
    load = 1'b0;
    rst = 1'b0;
    #1;

    // Reset state
    n_vec++;
    chk("reset_busy", -1, 32'(bus.busy), 0);
    chk("reset_gid", -1, 32'(bus.grant_id), 0);
    chk("reset_acks", -1, 32'({bus.p0_ack, bus.p0_err, bus.p1_ack, bus.p1_err}), 0);
    chk("reset_rdata0", -1, bus.p0_rdata, 0);
    chk("reset_rdata1", -1, bus.p1_rdata, 0);
    chk("reset_rw", -1, 32'(bus.mem_rw), 0);

    foreach (vecs[i]) begin
      rst = vecs[i].rst;
      bus.p0_req = vecs[i].r0; bus.p0_we = vecs[i].w0;
      bus.p0_addr = vecs[i].a0; bus.p0_wdata = vecs[i].d0;
      bus.p1_req = vecs[i].r1; bus.p1_we = vecs[i].w1;
      bus.p1_addr = vecs[i].a1; bus.p1_wdata = vecs[i].d1;
      #1;
      n_vec++;
      chk("ack_err", i, 32'({bus.p0_ack, bus.p0_err, bus.p1_ack, bus.p1_err}),
          32'(vecs[i].ae));
      chk("p0_rdata", i, bus.p0_rdata, vecs[i].rd0);
      chk("p1_rdata", i, bus.p1_rdata, vecs[i].rd1);
      chk("busy", i, 32'(bus.busy), 32'(vecs[i].busy));
      chk("grant_id", i, 32'(bus.grant_id), 32'(vecs[i].gid));
      chk("mem_rw", i, 32'(bus.mem_rw), 32'(vecs[i].rw));
      step();
    end
    rst = 1'b0;

    // Memory contents after the table
    n_vec++;
    chk("ram0", -1, ram[0], 0);
    chk("ram1", -1, ram[1], 1);
    chk("ram4", -1, ram[4], DB);
    chk("ram5", -1, ram[5], 25);

    // p1 write with a bounded wait for ack: expect ack two cycles after the request
    bus.p1_req = 1; bus.p1_we = 1; bus.p1_addr = 32'h1C; bus.p1_wdata = 32'hA5;
    #1;
    lat = 0;
    while (!bus.p1_ack && lat < 8) begin
      step();
      lat++;
    end
    n_vec++;
    chk("wr_ack_seen", -1, 32'(bus.p1_ack), 1);
    chk("wr_latency", -1, lat, 2);
    chk("wr_err", -1, 32'(bus.p1_err), 0);
    bus.p1_req = 0;
    step();
    n_vec++;
    chk("ram7", -1, ram[7], 32'hA5);
    chk("idle_busy", -1, 32'(bus.busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
